// File: rtl/alu_multicycle_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle_if
// Purpose  : Request/response bundle between EX-stage control and the ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_multicycle_if #(
    parameter int WORD_SIZE = 32
);
    logic                 start_in;
    logic [3:0]           alu_control_in;
    logic [WORD_SIZE-1:0] channel_a_in;
    logic [WORD_SIZE-1:0] channel_b_in;
    logic                 ready_out;
    logic                 done_out;
    logic [WORD_SIZE-1:0] result_out;
    logic                 zero_out;
    logic                 overflow_out;
    logic [WORD_SIZE-1:0] hi_out;
    logic [WORD_SIZE-1:0] lo_out;

    modport master (
        output start_in, alu_control_in, channel_a_in, channel_b_in,
        input  ready_out, done_out, result_out, zero_out, overflow_out, hi_out, lo_out
    );

    modport slave (
        input  start_in, alu_control_in, channel_a_in, channel_b_in,
        output ready_out, done_out, result_out, zero_out, overflow_out, hi_out, lo_out
    );
endinterface
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Purpose  : Registered EX-stage ALU with iterative mul/div into HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
    parameter int WORD_SIZE = 32
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    alu_multicycle_if.slave  bus
);
    localparam int SHAMT_W = $clog2(WORD_SIZE);
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    localparam logic [3:0] c_OP_AND   = 4'b0000;
    localparam logic [3:0] c_OP_OR    = 4'b0001;
    localparam logic [3:0] c_OP_ADD   = 4'b0010;
    localparam logic [3:0] c_OP_XOR   = 4'b0011;
    localparam logic [3:0] c_OP_SLL   = 4'b0100;
    localparam logic [3:0] c_OP_SRL   = 4'b0101;
    localparam logic [3:0] c_OP_SUB   = 4'b0110;
    localparam logic [3:0] c_OP_SLT   = 4'b0111;
    localparam logic [3:0] c_OP_SRA   = 4'b1000;
    localparam logic [3:0] c_OP_SLTU  = 4'b1001;
    localparam logic [3:0] c_OP_MULT  = 4'b1010;
    localparam logic [3:0] c_OP_MULTU = 4'b1011;
    localparam logic [3:0] c_OP_NOR   = 4'b1100;
    localparam logic [3:0] c_OP_DIV   = 4'b1101;
    localparam logic [3:0] c_OP_DIVU  = 4'b1110;

    logic [0:0]           r_state;
    logic                 r_ready;
    logic                 r_done;
    logic                 r_zero;
    logic                 r_ovf;
    logic [WORD_SIZE-1:0] r_result;
    logic [WORD_SIZE-1:0] r_hi;
    logic [WORD_SIZE-1:0] r_lo;
    logic [WORD_SIZE-1:0] r_acc_hi;
    logic [WORD_SIZE-1:0] r_acc_lo;
    logic [WORD_SIZE-1:0] r_opnd;
    logic [WORD_SIZE-1:0] r_op_a;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_div_zero;

    logic [WORD_SIZE-1:0] w_a;
    logic [WORD_SIZE-1:0] w_b;
    logic [3:0]           w_op;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [WORD_SIZE-1:0] w_sum;
    logic [WORD_SIZE-1:0] w_diff;
    logic [WORD_SIZE-1:0] w_res;
    logic                 w_ovf;
    logic                 w_accept;
    logic                 w_is_muldiv;
    logic                 w_is_div;
    logic                 w_signed_op;
    logic [WORD_SIZE-1:0] w_mag_a;
    logic [WORD_SIZE-1:0] w_mag_b;
    logic [WORD_SIZE:0]   w_mul_sum;
    logic [WORD_SIZE:0]   w_div_shift;
    logic                 w_div_ge;
    logic [WORD_SIZE-1:0] w_div_sub;
    logic [2*WORD_SIZE-1:0] w_prod;
    logic [2*WORD_SIZE-1:0] w_prod_fix;
    logic [WORD_SIZE-1:0] w_fin_hi;
    logic [WORD_SIZE-1:0] w_fin_lo;

    assign w_a      = bus.channel_a_in;
    assign w_b      = bus.channel_b_in;
    assign w_op     = bus.alu_control_in;
    assign w_shamt  = w_b[SHAMT_W-1:0];
    assign w_sum    = w_a + w_b;
    assign w_diff   = w_a - w_b;
    assign w_accept = bus.start_in && r_ready;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (w_op)
            c_OP_AND:  w_res = w_a & w_b;
            c_OP_OR:   w_res = w_a | w_b;
            c_OP_ADD: begin
                w_res = w_sum;
                w_ovf = (w_a[WORD_SIZE-1] == w_b[WORD_SIZE-1]) &&
                        (w_sum[WORD_SIZE-1] != w_a[WORD_SIZE-1]);
            end
            c_OP_XOR:  w_res = w_a ^ w_b;
            c_OP_SLL:  w_res = w_a << w_shamt;
            c_OP_SRL:  w_res = w_a >> w_shamt;
            c_OP_SUB: begin
                w_res = w_diff;
                w_ovf = (w_a[WORD_SIZE-1] != w_b[WORD_SIZE-1]) &&
                        (w_diff[WORD_SIZE-1] != w_a[WORD_SIZE-1]);
            end
            c_OP_SLT:  w_res = {{(WORD_SIZE-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            c_OP_SRA:  w_res = $signed(w_a) >>> w_shamt;
            c_OP_SLTU: w_res = {{(WORD_SIZE-1){1'b0}}, (w_a < w_b)};
            c_OP_NOR:  w_res = ~(w_a | w_b);
            default:   w_res = '0;
        endcase
    end

    assign w_is_div    = (w_op == c_OP_DIV) || (w_op == c_OP_DIVU);
    assign w_is_muldiv = w_is_div || (w_op == c_OP_MULT) || (w_op == c_OP_MULTU);
    assign w_signed_op = (w_op == c_OP_MULT) || (w_op == c_OP_DIV);
    assign w_mag_a     = (w_signed_op && w_a[WORD_SIZE-1]) ? -w_a : w_a;
    assign w_mag_b     = (w_signed_op && w_b[WORD_SIZE-1]) ? -w_b : w_b;

    // Multiply: add multiplicand into the upper half, shift the pair right.
    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
    // Divide: partial remainder lives in r_acc_hi, dividend/quotient in r_acc_lo.
    assign w_div_shift = {r_acc_hi, r_acc_lo[WORD_SIZE-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_sub   = w_div_shift[WORD_SIZE-1:0] - r_opnd;

    assign w_prod      = {r_acc_hi, r_acc_lo};
    assign w_prod_fix  = r_neg_q ? -w_prod : w_prod;

    always_comb begin
        w_fin_hi = w_prod_fix[2*WORD_SIZE-1:WORD_SIZE];
        w_fin_lo = w_prod_fix[WORD_SIZE-1:0];
        if (r_is_div) begin
            if (r_div_zero) begin
                w_fin_hi = r_op_a;
                w_fin_lo = '1;
            end else begin
                w_fin_hi = r_neg_r ? -r_acc_hi : r_acc_hi;
                w_fin_lo = r_neg_q ? -r_acc_lo : r_acc_lo;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= c_IDLE;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_result   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_opnd     <= '0;
            r_op_a     <= '0;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (w_is_muldiv) begin
                            r_state    <= c_BUSY;
                            r_ready    <= 1'b0;
                            r_cnt      <= '0;
                            r_acc_hi   <= '0;
                            r_acc_lo   <= w_is_div ? w_mag_a : w_mag_b;
                            r_opnd     <= w_is_div ? w_mag_b : w_mag_a;
                            r_op_a     <= w_a;
                            r_is_div   <= w_is_div;
                            r_neg_q    <= w_signed_op && (w_a[WORD_SIZE-1] ^ w_b[WORD_SIZE-1]);
                            r_neg_r    <= w_signed_op && w_a[WORD_SIZE-1];
                            r_div_zero <= w_is_div && (w_b == '0);
                        end else begin
                            r_result <= w_res;
                            r_zero   <= (w_res == '0);
                            r_ovf    <= w_ovf;
                            r_done   <= 1'b1;
                        end
                    end
                end
                c_BUSY: begin
                    if (r_cnt == CNT_W'(WORD_SIZE)) begin
                        r_hi     <= w_fin_hi;
                        r_lo     <= w_fin_lo;
                        r_result <= w_fin_lo;
                        r_zero   <= (w_fin_lo == '0);
                        r_ovf    <= 1'b0;
                        r_done   <= 1'b1;
                        r_ready  <= 1'b1;
                        r_state  <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_is_div) begin
                            r_acc_hi <= w_div_ge ? w_div_sub : w_div_shift[WORD_SIZE-1:0];
                            r_acc_lo <= {r_acc_lo[WORD_SIZE-2:0], w_div_ge};
                        end else begin
                            r_acc_hi <= w_mul_sum[WORD_SIZE:1];
                            r_acc_lo <= {w_mul_sum[0], r_acc_lo[WORD_SIZE-1:1]};
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.ready_out    = r_ready;
    assign bus.done_out     = r_done;
    assign bus.result_out   = r_result;
    assign bus.zero_out     = r_zero;
    assign bus.overflow_out = r_ovf;
    assign bus.hi_out       = r_hi;
    assign bus.lo_out       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Purpose  : Randomized and directed self-checking bench for alu_multicycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_multicycle_if #(.WORD_SIZE(W)) bus ();

    alu_multicycle #(.WORD_SIZE(W)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour computed with wide signed arithmetic.
    function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] res, output logic ov, output logic md,
                                      output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint sa  = longint'($signed(a));
        longint sb  = longint'($signed(b));
        longint lim = 64'sd1 <<< 31;
        longint s;
        logic [63:0] p;
        int sh = int'(b % 32);
        res = '0; ov = 1'b0; md = 1'b0; hi = '0; lo = '0;
        case (op)
            4'd0:  res = a & b;
            4'd1:  res = a | b;
            4'd2:  begin s = sa + sb; res = s[W-1:0]; ov = (s >= lim) || (s < -lim); end
            4'd3:  res = a ^ b;
            4'd4:  res = a << sh;
            4'd5:  res = a >> sh;
            4'd6:  begin s = sa - sb; res = s[W-1:0]; ov = (s >= lim) || (s < -lim); end
            4'd7:  res = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  begin s = sa >>> sh; res = s[W-1:0]; end
            4'd9:  res = (a < b) ? 32'd1 : 32'd0;
            4'd10: begin md = 1'b1; s = sa * sb; p = s; hi = p[63:32]; lo = p[31:0]; end
            4'd11: begin md = 1'b1; p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            4'd12: res = ~(a | b);
            4'd13: begin
                md = 1'b1;
                if (b == '0) begin lo = '1; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = '0; end
                else begin s = sa / sb; lo = s[W-1:0]; s = sa % sb; hi = s[W-1:0]; end
            end
            4'd14: begin
                md = 1'b1;
                if (b == '0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            default: res = '0;
        endcase
        if (md) res = lo;
    endfunction

    task automatic drive(input logic st, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start_in       = st;
        bus.alu_control_in = op;
        bus.channel_a_in   = a;
        bus.channel_b_in   = b;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] e_res, e_hi, e_lo;
        logic e_ov, e_md;
        int cyc;
        ref_model(op, a, b, e_res, e_ov, e_md, e_hi, e_lo);
        @(negedge clk);
        drive(1'b1, op, a, b);
        @(posedge clk); #1;
        if (!e_md) begin
            check_val({tag, ".done"},  64'(bus.done_out), 64'(1));
            check_val({tag, ".res"},   64'(bus.result_out), 64'(e_res));
            check_val({tag, ".zero"},  64'(bus.zero_out), 64'(e_res == '0));
            check_val({tag, ".ovf"},   64'(bus.overflow_out), 64'(e_ov));
            check_val({tag, ".hi"},    64'(bus.hi_out), 64'(exp_hi));
            check_val({tag, ".lo"},    64'(bus.lo_out), 64'(exp_lo));
            @(negedge clk);
            bus.start_in = 1'b0;
        end else begin
            check_val({tag, ".busy"}, 64'(bus.ready_out), 64'(0));
            cyc = 0;
            while (cyc < 60) begin
                @(negedge clk);
                // A competing request mid-operation must be ignored.
                if (cyc >= 3 && cyc <= 5)
                    drive(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
                else
                    bus.start_in = 1'b0;
                @(posedge clk); #1;
                cyc++;
                if (bus.done_out) break;
            end
            check_val({tag, ".latency"}, 64'(cyc), 64'(W + 1));
            check_val({tag, ".res"},     64'(bus.result_out), 64'(e_lo));
            check_val({tag, ".zero"},    64'(bus.zero_out), 64'(e_lo == '0));
            check_val({tag, ".ovf"},     64'(bus.overflow_out), 64'(0));
            check_val({tag, ".hi"},      64'(bus.hi_out), 64'(e_hi));
            check_val({tag, ".lo"},      64'(bus.lo_out), 64'(e_lo));
            check_val({tag, ".ready"},   64'(bus.ready_out), 64'(1));
            exp_hi = e_hi;
            exp_lo = e_lo;
        end
    endtask

    logic [3:0]   bb_op [3];
    logic [W-1:0] bb_a  [3];
    logic [W-1:0] bb_b  [3];

    initial begin
        logic [W-1:0] e_res, e_hi, e_lo;
        logic e_ov, e_md;
        int dones;
        drive(1'b0, 4'd0, '0, '0);

        repeat (2) @(posedge clk);
        #1;
        check_val("rst.ready",  64'(bus.ready_out), 64'(1));
        check_val("rst.done",   64'(bus.done_out), 64'(0));
        check_val("rst.res",    64'(bus.result_out), 64'(0));
        check_val("rst.zero",   64'(bus.zero_out), 64'(0));
        check_val("rst.ovf",    64'(bus.overflow_out), 64'(0));
        check_val("rst.hi",     64'(bus.hi_out), 64'(0));
        check_val("rst.lo",     64'(bus.lo_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        bb_op[0] = 4'b0010; bb_a[0] = 32'h7FFF_FFFF; bb_b[0] = 32'h1;
        bb_op[1] = 4'b0110; bb_a[1] = 32'd5;         bb_b[1] = 32'd5;
        bb_op[2] = 4'b1000; bb_a[2] = 32'h8000_0000; bb_b[2] = 32'h24;
        for (int i = 0; i < 3; i++) begin
            ref_model(bb_op[i], bb_a[i], bb_b[i], e_res, e_ov, e_md, e_hi, e_lo);
            @(negedge clk);
            drive(1'b1, bb_op[i], bb_a[i], bb_b[i]);
            @(posedge clk); #1;
            check_val($sformatf("b2b%0d.done", i),  64'(bus.done_out), 64'(1));
            check_val($sformatf("b2b%0d.ready", i), 64'(bus.ready_out), 64'(1));
            check_val($sformatf("b2b%0d.res", i),   64'(bus.result_out), 64'(e_res));
            check_val($sformatf("b2b%0d.zero", i),  64'(bus.zero_out), 64'(e_res == '0));
            check_val($sformatf("b2b%0d.ovf", i),   64'(bus.overflow_out), 64'(e_ov));
        end
        @(negedge clk);
        bus.start_in = 1'b0;

        run_op("slt",   4'b0111, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu",  4'b1001, 32'hFFFF_FFFF, 32'd1);
        run_op("rsvd",  4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op("mult",  4'b1010, 32'hFFFF_FFFE, 32'd3);
        run_op("div",   4'b1101, 32'hFFFF_FFF9, 32'd2);
        run_op("divu",  4'b1110, 32'd100,       32'd7);
        run_op("divu0", 4'b1110, 32'd5,         32'd0);
        run_op("divmn", 4'b1101, 32'h8000_0000, 32'hFFFF_FFFF);

        // Abort a MULTU with reset in its fifth cycle.
        @(negedge clk);
        drive(1'b1, 4'b1011, 32'hDEAD_BEEF, 32'h1234_5678);
        @(posedge clk);
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort.ready", 64'(bus.ready_out), 64'(1));
        check_val("abort.done",  64'(bus.done_out), 64'(0));
        check_val("abort.res",   64'(bus.result_out), 64'(0));
        check_val("abort.hi",    64'(bus.hi_out), 64'(0));
        check_val("abort.lo",    64'(bus.lo_out), 64'(0));
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done_out) dones++;
        end
        check_val("abort.nodone", 64'(dones), 64'(0));

        for (int i = 0; i < 150; i++) begin
            logic [3:0]   op;
            logic [W-1:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = '1;
                2:       b = $urandom_range(0, 40);
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
